// File: rtl/ball_control.sv
// ball_control: Breakout ball position/velocity with wall, paddle and brick bounces plus life tracking.
module ball_control #(
    parameter int X_MIN      = 8,
    parameter int X_MAX      = 310,
    parameter int Y_MIN      = 8,
    parameter int Y_LOST     = 236,
    parameter int PADDLE_Y   = 220,
    parameter int SERVE_OFS  = 15,
    parameter int LIVES_INIT = 3
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       frame_tick,
    input  logic       launch,
    input  logic [2:0] paddle_hit,
    input  logic [8:0] paddle_x,
    input  logic [1:0] brick_hit,
    output logic [8:0] ball_x,
    output logic [7:0] ball_y,
    output logic       draw,
    output logic [1:0] lives,
    output logic       life_lost,
    output logic       game_over,
    output logic [1:0] state
);
    typedef enum logic [1:0] {SERVE, MOVE, LOST, OVER} state_t;
    localparam logic signed [9:0] XMN = 10'(X_MIN);
    localparam logic signed [9:0] XMX = 10'(X_MAX);
    localparam logic signed [9:0] YMN = 10'(Y_MIN);
    localparam logic signed [9:0] YLS = 10'(Y_LOST);
    state_t            st, st_nxt;
    logic signed [2:0] dx, dx_nxt, pdx, bdx, adx;
    logic signed [1:0] dy, dy_nxt, pdy, bdy;
    logic signed [9:0] nx, ny;
    logic        [8:0] x_nxt;
    logic        [7:0] y_nxt;
    logic        [1:0] lives_nxt;
    logic              p_set, hit_l, hit_r, hit_t;

    assign state = st;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            st        <= SERVE;
            ball_x    <= 9'd167;
            ball_y    <= 8'd216;
            dx        <= 3'sd1;
            dy        <= -2'sd1;
            lives     <= 2'(LIVES_INIT);
            draw      <= 1'b1;
            life_lost <= 1'b0;
            game_over <= 1'b0;
        end else begin
            st        <= st_nxt;
            ball_x    <= x_nxt;
            ball_y    <= y_nxt;
            dx        <= dx_nxt;
            dy        <= dy_nxt;
            lives     <= lives_nxt;
            draw      <= frame_tick && (st == SERVE || st == MOVE);
            life_lost <= st == LOST;
            game_over <= game_over || (st == LOST && lives == 2'd1);
        end
    end

    always_comb begin
        st_nxt = st;
        if (st == SERVE && frame_tick && launch) st_nxt = MOVE;
        if (st == MOVE && frame_tick && ny >= YLS) st_nxt = LOST;
        if (st == LOST) st_nxt = lives == 2'd1 ? OVER : SERVE;
    end

    // Paddle first, then brick (its dy flip masked by a paddle bounce), then advance and clamp at walls.
    always_comb begin
        p_set = st == MOVE && dy == 2'sd1 && paddle_hit inside {[3'd1:3'd5]};
        pdx = !p_set ? dx :
              paddle_hit == 3'd1 ? -3'sd2 :
              paddle_hit == 3'd2 ? -3'sd1 :
              paddle_hit == 3'd3 ? (dx[2] ? -3'sd1 : 3'sd1) :
              paddle_hit == 3'd4 ? 3'sd1 : 3'sd2;
        pdy = p_set ? -2'sd1 : dy;
        bdx = brick_hit[0] ? -pdx : pdx;
        bdy = (brick_hit[1] && !p_set) ? -pdy : pdy;
        adx = bdx[2] ? -bdx : bdx;
        nx = {1'b0, ball_x} + {{7{bdx[2]}}, bdx};
        ny = {2'b0, ball_y} + {{8{bdy[1]}}, bdy};
        hit_l = nx <= XMN;
        hit_r = nx >= XMX;
        hit_t = ny <= YMN;
        x_nxt  = ball_x;
        y_nxt  = ball_y;
        dx_nxt = dx;
        dy_nxt = dy;
        if (frame_tick && st == SERVE) begin
            x_nxt  = paddle_x + 9'(SERVE_OFS);
            y_nxt  = 8'(PADDLE_Y - 4);
            dx_nxt = launch ? 3'sd1 : dx;
            dy_nxt = launch ? -2'sd1 : dy;
        end
        if (frame_tick && st == MOVE) begin
            x_nxt  = hit_l ? 9'(X_MIN) : hit_r ? 9'(X_MAX) : nx[8:0];
            dx_nxt = hit_l ? adx : hit_r ? -adx : bdx;
            y_nxt  = hit_t ? 8'(Y_MIN) : ny[7:0];
            dy_nxt = hit_t ? 2'sd1 : bdy;
        end
        if (st == LOST && lives != 2'd1) begin
            dx_nxt = 3'sd1;
            dy_nxt = -2'sd1;
        end
        lives_nxt = (st == LOST && lives != 2'd0) ? lives - 2'd1 : lives;
    end
endmodule

// File: doc/ball_control.md
Name: ball_control

Overview:
- Owns ball position and velocity for the Breakout playfield, advancing once per frame tick.
- Consumes the paddle block's outputs: PADDLE_HIT zone code (0 = no hit, 1..5 = zone) and paddle left x.
- Consumes brick-collision codes from the brick block.
- Produces ball_x/ball_y for the paddle collision check and the renderer, plus life/game-over status to the top-level FSM.

Parameters:
- X_MIN, 8, leftmost legal ball_x (inner edge of left wall).
- X_MAX, 310, rightmost legal ball_x.
- Y_MIN, 8, topmost legal ball_y.
- Y_LOST, 236, ball_y at or below which the ball is lost.
- PADDLE_Y, 220, paddle top row; serve row is PADDLE_Y-4.
- SERVE_OFS, 15, ball_x offset from paddle_x while serving.
- LIVES_INIT, 3, lives loaded at reset.

Ports:
- clk, input, 1, system clock.
- resetn, input, 1, reset, synchronous, active-low.
- frame_tick, input, 1, one-clk pulse per frame (60 Hz); all motion is gated by it.
- launch, input, 1, level; serve request sampled on frame_tick.
- paddle_hit, input, 3, zone code from paddle block: 0 none, 1..5 zone left→right.
- paddle_x, input, 9, paddle left x.
- brick_hit, input, 2, 00 none, 01 side face (flip dx), 10 top/bottom face (flip dy), 11 corner (flip both).
- ball_x, output, 9, ball x (registered).
- ball_y, output, 8, ball y (registered).
- draw, output, 1, one-clk pulse after each position update.
- lives, output, 2, remaining lives.
- life_lost, output, 1, one-clk pulse when a ball is lost.
- game_over, output, 1, level; held until reset.
- state, output, 2, 0 SERVE, 1 MOVE, 2 LOST, 3 OVER.

Behaviour:
- Reset (resetn=0 at posedge): state=SERVE, ball_x=167, ball_y=216, dx=+1, dy=-1, lives=LIVES_INIT, draw=1, life_lost=0, game_over=0. Reset wins over every other event, including mid-flight.
- Velocity: dx signed 3-bit in {-2,-1,+1,+2}; dy signed 2-bit in {-1,+1}.
- draw: 1 for exactly the clk after any frame_tick in SERVE or MOVE; otherwise 0.
- Outside frame_tick, all registers hold, except the LOST transition and the life_lost pulse.
- SERVE, on frame_tick:
  - ball_x=paddle_x+SERVE_OFS, ball_y=PADDLE_Y-4.
  - If launch=1: dx=+1, dy=-1, state→MOVE. The ball does not move on this tick.
- MOVE, on frame_tick, in this order, all in one edge:
  1. Paddle: if paddle_hit!=0 and dy=+1, set dy=-1 and map dx by zone: 1→-2, 2→-1, 3→keep sign with magnitude 1, 4→+1, 5→+2. Ignore paddle_hit when dy=-1; ignore codes 6/7.
  2. Brick: flip dx and/or dy per brick_hit. If the paddle already set dy this tick, the brick's dy flip is suppressed; its dx flip still applies.
  3. Advance: nx=ball_x+dx, ny=ball_y+dy using the updated dx/dy, computed 10-bit signed.
  4. Walls:
     - nx<=X_MIN → ball_x=X_MIN, dx=+|dx|.
     - nx>=X_MAX → ball_x=X_MAX, dx=-|dx|.
     - ny<=Y_MIN → ball_y=Y_MIN, dy=+1.
     - Otherwise store nx/ny.
  5. Loss: if ny>=Y_LOST, state→LOST; the position is still stored.
- LOST (one clk, no tick needed):
  - life_lost=1, lives=lives-1.
  - If the old lives==1 → OVER, game_over=1. Otherwise → SERVE with dx=+1, dy=-1.
  - Saturate lives at 0; it never wraps.
- OVER: all outputs frozen, draw=0, frame_tick and launch ignored; only reset exits.
- Corner case: wall and brick flip on the same tick both apply. The wall's absolute-sign rule is evaluated last, so the ball always ends moving away from the wall.

Test Plan:
- Reset then no ticks → ball_x=167, ball_y=216, lives=3, state=0, draw=1 for one clk, then 0.
- SERVE, paddle_x=100, tick with launch=0 → ball_x=115, ball_y=216. Next tick launch=1 → state=1, position unchanged. Next tick → (116,215).
- MOVE, ball_x=309, dx=+2, dy=-1, tick → ball_x=310, dx=-2. Next tick → ball_x=308.
- dy=+1, paddle_hit=1,2,3,4,5 on successive serves → dx=-2,-1,±1 (sign kept),+1,+2, dy=-1. paddle_hit=3 with dy=-1 → no change.
- ball_y=235, dy=+1, no hit, tick → ball_y=236, state=LOST. Next clk: life_lost=1, lives=2, state=SERVE. Repeat until lives=1 → lost → game_over=1, state=3, lives=0. Further ticks change nothing.
- brick_hit=11 at ball_x=9, dx=-1: flip → +1, advance to 10, moving right. Apply resetn=0 mid-MOVE → all reset values on the next edge.
